// File: rtl/and_priority_encoder_pkg.sv
// rtl/and_priority_encoder_pkg.sv - shared sizing for the sparse-match engine
package and_priority_encoder_pkg;

  // Bitmap width of one prefix-sum chunk.
  localparam int PREFIX_SUM_SIZE = 32;

  // Width of a match index within one chunk.
  localparam int PSUM_AW = $clog2(PREFIX_SUM_SIZE);

endpackage

// File: rtl/and_priority_encoder_prio_enc_lsb.sv
// rtl/and_priority_encoder_prio_enc_lsb.sv - log-depth lowest-set-bit encoder
module prio_enc_lsb
  import and_priority_encoder_pkg::*;
#(
  parameter int N = PREFIX_SUM_SIZE
) (
  input  logic [N-1:0]         cand_i,
  output logic [$clog2(N):0]   enc_o
);

  localparam int AW = $clog2(N);

  // Level l holds N>>l nodes; each node reports whether any bit in its
  // 2^l-bit span is set and the offset of the lowest one within that span.
  // Pairs are merged upward, preferring the lower-index child.
  for (genvar l = 0; l <= AW; l++) begin : gen_lvl
    localparam int W = N >> l;
    logic [W-1:0]  v;
    logic [AW-1:0] ix [W];

    if (l == 0) begin : g_leaf
      assign v = cand_i;
      for (genvar k = 0; k < W; k++) begin : g_bit
        assign ix[k] = '0;
      end
    end else begin : g_node
      // Offset of the upper child's span inside the merged span.
      localparam logic [AW-1:0] OFF = AW'(1) << (l - 1);
      for (genvar k = 0; k < W; k++) begin : g_pair
        assign v[k]  = gen_lvl[l-1].v[2*k] | gen_lvl[l-1].v[2*k+1];
        assign ix[k] = gen_lvl[l-1].v[2*k] ? gen_lvl[l-1].ix[2*k]
                                           : (gen_lvl[l-1].ix[2*k+1] | OFF);
      end
    end
  end

  // An empty vector encodes as N, i.e. only the top bit set.
  assign enc_o = gen_lvl[AW].v[0] ? {1'b0, gen_lvl[AW].ix[0]} : (AW + 1)'(N);

endmodule

// File: rtl/and_priority_encoder.sv
// rtl/and_priority_encoder.sv - AND two bitmaps and emit matches lowest-first
module and_priority_encoder
  import and_priority_encoder_pkg::*;
#(
  parameter int N = PREFIX_SUM_SIZE
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic                 chunk_start_i,
  input  logic [N-1:0]         in1_i,
  input  logic [N-1:0]         in2_i,
  output logic                 valid_o,
  output logic [$clog2(N)-1:0] match_addr_o,
  output logic                 pri_enc_last_o
);

  localparam int AW = $clog2(N);

  logic [N-1:0] pend_q;
  logic [N-1:0] pend_d;
  logic [N-1:0] and_w;
  logic [N-1:0] cand_w;
  logic [N-1:0] clr_w;
  logic [AW:0]  enc_w;
  logic         empty_w;

  assign and_w  = in1_i & in2_i;
  assign cand_w = chunk_start_i ? and_w : pend_q;

  prio_enc_lsb #(
    .N (N)
  ) u_enc (
    .cand_i (cand_w),
    .enc_o  (enc_w)
  );

  // enc_w == N exactly when its top bit is set, since N is a power of two.
  assign empty_w = enc_w[AW];

  // Strip the bit being reported this cycle; an empty candidate stays empty.
  always_comb begin
    clr_w  = empty_w ? '0 : (N'(1) << enc_w[AW-1:0]);
    pend_d = cand_w & ~clr_w;
  end

  assign match_addr_o   = enc_w[AW-1:0];
  assign valid_o        = valid_i & ~empty_w;
  assign pri_enc_last_o = valid_i & (pend_d == '0);

  // Pending matches advance only on qualified cycles; reset drops them.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pend_q <= '0;
    end else if (valid_i) begin
      pend_q <= pend_d;
    end
  end

endmodule

// File: tb/tb_and_priority_encoder.sv
// tb/tb_and_priority_encoder.sv - bench for and_priority_encoder
module tb_and_priority_encoder;
  import and_priority_encoder_pkg::*;

  localparam int N = PREFIX_SUM_SIZE;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               valid_i;
  logic               chunk_start_i;
  logic [N-1:0]       in1_i;
  logic [N-1:0]       in2_i;
  logic               valid_o;
  logic [PSUM_AW-1:0] match_addr_o;
  logic               pri_enc_last_o;

  and_priority_encoder #(.N(N)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .valid_i        (valid_i),
    .chunk_start_i  (chunk_start_i),
    .in1_i          (in1_i),
    .in2_i          (in2_i),
    .valid_o        (valid_o),
    .match_addr_o   (match_addr_o),
    .pri_enc_last_o (pri_enc_last_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string              name;
    logic               rst_n;
    logic               vld;
    logic               cs;
    logic [N-1:0]       a;
    logic [N-1:0]       b;
    logic               ev;
    logic [PSUM_AW-1:0] ea;
    logic               el;
  } vec_t;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference state: outstanding match indices of the current chunk, ascending.
  int pend_q[$];

  task automatic model_step(input logic r, input logic v, input logic c,
                            input logic [N-1:0] a, input logic [N-1:0] b,
                            output logic ev, output logic [PSUM_AW-1:0] ea,
                            output logic el);
    int cand[$];
    if (!r) pend_q.delete();
    if (c) begin
      cand.delete();
      for (int i = 0; i < N; i++) if (a[i] && b[i]) cand.push_back(i);
    end else begin
      cand = pend_q;
    end
    ev = v && (cand.size() > 0);
    ea = (cand.size() > 0) ? PSUM_AW'(cand[0]) : '0;
    el = v && (cand.size() <= 1);
    if (r && v) begin
      if (cand.size() > 0) void'(cand.pop_front());
      pend_q = cand;
    end
  endtask

  task automatic drive_and_sample(input logic r, input logic v, input logic c,
                                  input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic ov, output logic [PSUM_AW-1:0] oa,
                                  output logic ol);
    @(negedge clk_i);
    rst_i = r; valid_i = v; chunk_start_i = c; in1_i = a; in2_i = b;
    #2;
    ov = valid_o; oa = match_addr_o; ol = pri_enc_last_o;
  endtask

  task automatic check(input string name, input logic ov, input logic [PSUM_AW-1:0] oa,
                       input logic ol, input logic ev, input logic [PSUM_AW-1:0] ea,
                       input logic el);
    n_vec++;
    if (ov !== ev || ol !== el || (ev && oa !== ea)) begin
      n_fail++;
      $display("FAIL %s: got valid=%0b addr=%0d last=%0b, want valid=%0b addr=%0d last=%0b",
               name, ov, oa, ol, ev, ea, el);
    end
  endtask

  vec_t tbl[$];

  function automatic vec_t mk(string nm, logic r, logic v, logic c, logic [N-1:0] a,
                              logic [N-1:0] b, logic ev, int ea, logic el);
    vec_t t;
    t.name = nm; t.rst_n = r; t.vld = v; t.cs = c; t.a = a; t.b = b;
    t.ev = ev; t.ea = PSUM_AW'(ea); t.el = el;
    return t;
  endfunction

  initial begin
    logic               ov, ol, mv, ml;
    logic [PSUM_AW-1:0] oa, ma;
    logic               r, v, c;
    logic [N-1:0]       a, b;

    rst_i = 1'b0; valid_i = 1'b0; chunk_start_i = 1'b0; in1_i = '0; in2_i = '0;

    tbl.push_back(mk("reset_hold",    0, 0, 0, 32'hDEAD_BEEF, 32'h1234_5678, 0, 0, 0));
    tbl.push_back(mk("reset_release", 1, 1, 0, 32'hDEAD_BEEF, 32'h1234_5678, 0, 0, 1));
    tbl.push_back(mk("three_m0",      1, 1, 1, 32'h0000_00F1, 32'h0000_0091, 1, 0, 0));
    tbl.push_back(mk("three_m1",      1, 1, 0, 32'h0,         32'h0,         1, 4, 0));
    tbl.push_back(mk("three_m2",      1, 1, 0, 32'h0,         32'h0,         1, 7, 1));
    tbl.push_back(mk("three_drained", 1, 1, 0, 32'h0,         32'h0,         0, 0, 1));
    tbl.push_back(mk("empty_chunk",   1, 1, 1, 32'hFFFF_0000, 32'h0000_FFFF, 0, 0, 1));
    tbl.push_back(mk("single_bit31",  1, 1, 1, 32'h8000_0000, 32'h8000_0000, 1, 31, 1));
    tbl.push_back(mk("stall_load",    1, 1, 1, 32'h0000_0006, 32'h0000_0006, 1, 1, 0));
    tbl.push_back(mk("stall_idle0",   1, 0, 0, 32'h0,         32'h0,         0, 0, 0));
    tbl.push_back(mk("stall_idle_cs", 1, 0, 1, 32'h0000_00FF, 32'h0000_00FF, 0, 0, 0));
    tbl.push_back(mk("stall_resume",  1, 1, 0, 32'h0,         32'h0,         1, 2, 1));
    tbl.push_back(mk("restart_load",  1, 1, 1, 32'h0000_0F01, 32'h0000_0F01, 1, 0, 0));
    tbl.push_back(mk("restart_new0",  1, 1, 1, 32'h0000_0003, 32'h0000_0003, 1, 0, 0));
    tbl.push_back(mk("restart_new1",  1, 1, 0, 32'h0,         32'h0,         1, 1, 1));
    tbl.push_back(mk("restart_done",  1, 1, 0, 32'h0,         32'h0,         0, 0, 1));
    tbl.push_back(mk("midrst_load",   1, 1, 1, 32'h0000_00F0, 32'h0000_00F0, 1, 4, 0));
    tbl.push_back(mk("midrst_assert", 0, 1, 0, 32'h0,         32'h0,         0, 0, 1));
    tbl.push_back(mk("midrst_after",  1, 1, 0, 32'h0,         32'h0,         0, 0, 1));
    tbl.push_back(mk("idle_empty",    1, 0, 0, 32'h0,         32'h0,         0, 0, 0));

    foreach (tbl[i]) begin
      drive_and_sample(tbl[i].rst_n, tbl[i].vld, tbl[i].cs, tbl[i].a, tbl[i].b, ov, oa, ol);
      model_step(tbl[i].rst_n, tbl[i].vld, tbl[i].cs, tbl[i].a, tbl[i].b, mv, ma, ml);
      check(tbl[i].name, ov, oa, ol, tbl[i].ev, tbl[i].ea, tbl[i].el);
    end

    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 59) != 0);
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 6) == 0);
      case ($urandom_range(0, 3))
        0: begin a = $urandom & $urandom & $urandom; b = $urandom & $urandom; end
        1: begin a = $urandom; b = $urandom; end
        2: begin a = N'(1) << $urandom_range(0, N - 1); b = '1; end
        default: begin a = $urandom & $urandom; b = $urandom & $urandom & $urandom; end
      endcase
      drive_and_sample(r, v, c, a, b, ov, oa, ol);
      model_step(r, v, c, a, b, mv, ma, ml);
      check("random", ov, oa, ol, mv, ma, ml);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/and_priority_encoder.md
Name: and_priority_encoder

Overview:
- Sparse-match engine for the NPU datapath.
- ANDs an IFM non-zero bitmap with a filter non-zero bitmap, then reports the matching bit positions one per cycle, lowest index first, until the chunk is exhausted.
- Sits between the bitmap fetch stage and the prefix-sum/address-generation stage.
- Built from a combinational AND stage, a combinational priority encoder, and a pending-match register.

Parameters:
- N, 32: bitmap width (PREFIX_SUM_SIZE); power of two, at least 2.
- AW, $clog2(N): match address width (derived; not overridable).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-low reset (asserted at 0).
- valid_i  input  1  cycle qualifier; state advances only when 1.
- chunk_start_i  input  1  first cycle of a new chunk; load fresh bitmaps.
- in1_i  input  N  IFM non-zero bitmap.
- in2_i  input  N  filter non-zero bitmap.
- valid_o  output  1  match_addr_o holds a real match this cycle.
- match_addr_o  output  AW  index of the lowest set pending bit.
- pri_enc_last_o  output  1  this is the final match of the chunk, or the chunk is empty.

Behaviour:
- and_w = in1_i & in2_i (combinational).
- Candidate vector cand_w = chunk_start_i ? and_w : pend_r.
- Priority encoder:
  - enc_w has width AW+1 and equals the index of the lowest set bit of cand_w.
  - enc_w = N when cand_w is all zero.
- match_addr_o = enc_w[AW-1:0]. When no match, this field wraps to 0 and is meaningless.
- valid_o = valid_i && (enc_w != N).
- next_w = cand_w with bit enc_w[AW-1:0] cleared; when enc_w == N, next_w = cand_w unchanged.
- pri_enc_last_o = valid_i && (next_w == 0). It asserts on the last match and also on an empty candidate vector.
- All outputs are combinational from the inputs and pend_r (zero-latency).
- pend_r update on the rising clock edge:
  - rst_i == 0 (async): pend_r <= 0.
  - Else if valid_i: pend_r <= next_w. This loads the new chunk minus its first match, or clears the reported bit.
  - Else: hold.
- chunk_start_i without valid_i changes no state. Outputs are still forced to 0 valid/last by valid_i gating.
- chunk_start_i mid-chunk discards the remaining pending bits and restarts on the new bitmaps.
- Reset mid-chunk:
  - Pending bits are lost.
  - After release, with no chunk_start, cand = 0, so valid_o = 0 and last_o = valid_i.
- Throughput: one match per valid cycle. A chunk with K matches needs K valid cycles; last_o is high on the K-th.
- An upstream controller stops issuing valid_i for the chunk after last_o.

Decomposition:
- Shared package: PREFIX_SUM_SIZE constant and the derived address-width localparam.
- Natural sub-modules:
  - prio_enc_lsb: combinational lowest-set-bit encoder of width N, output width AW+1, value N when empty; implement as a log-depth tree.
  - The AND stage is a single assign; no sub-module.

Test Plan:
- Reset: drive rst_i=0 with random inputs, then release with valid_i=1, chunk_start_i=0 -> valid_o=0, pri_enc_last_o=1, pend_r=0.
- Three matches:
  - Stimulus: in1=0x0000_00F1, in2=0x0000_0091, chunk_start on cycle 0, valid held high 3 cycles.
  - Response: addr 0, 4, 7 on consecutive cycles; valid_o=1 each; last_o=0,0,1; pend_r=0 after.
- Empty chunk: in1=0xFFFF_0000, in2=0x0000_FFFF with chunk_start and valid -> valid_o=0, pri_enc_last_o=1.
- Single bit 31: in1=in2=0x8000_0000 -> addr 31, valid_o=1, last_o=1 in the same cycle.
- Stall:
  - Stimulus: bitmap 0x0000_0006 loaded, then valid_i=0 for 2 cycles, then valid_i=1.
  - Response: addr 1, last_o=0; outputs 0 during the stall; then addr 2, last_o=1.
- Restart: mid-chunk (pend=0x0000_0F00), chunk_start with and=0x0000_0003 -> addr 0 next, then 1 with last_o=1; the old bits never appear.
